// File: rtl/dual_slope_sequencer.sv
// dual_slope_sequencer
//   Sequences one dual-slope ADC conversion: auto-zero, fixed-time signal
//   integration, then reference de-integration. It counts de-integrate clocks
//   until the zero-cross comparator fires.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   conversion request, sampled only in IDLE
//   abort      in   cancel conversion, sampled in AZ/INT/DEINT
//   vint_z     in   integrator zero-cross comparator (clk-synchronous)
//   ch_vm      out  Vin -> integrator switch
//   ch_ref     out  Vref -> integrator switch
//   ch_zr      out  integrator short switch
//   busy       out  high in AZ/INT/DEINT
//   valid      out  one-cycle pulse, result/overrange valid
//   result     out  de-integrate count of the last completed conversion
//   overrange  out  last conversion timed out in DEINT
module dual_slope_sequencer #(
  parameter int unsigned N_AZ  = 16,
  parameter int unsigned N_INT = 1000,
  parameter int unsigned N_MAX = 2000,
  parameter int unsigned CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             vint_z,
  output logic             ch_vm,
  output logic             ch_ref,
  output logic             ch_zr,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] result,
  output logic             overrange
);

  typedef enum logic [2:0] {
    StIdle,
    StAz,
    StInt,
    StDeint,
    StDone
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ch_vm;
  logic               r_ch_ref;
  logic               r_ch_zr;
  logic               r_busy;
  logic               r_valid;
  logic [CNT_W-1:0]   r_result;
  logic               r_overrange;
  logic               w_deint_end;

  // A DEINT cycle terminates the conversion on zero-cross or on the last
  // allowed count; abort overrides both.
  assign w_deint_end = (r_state == StDeint) && !abort &&
                       (vint_z || (r_cnt == CNT_W'(N_MAX - 1)));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) w_state_nxt = StAz;
      end
      StAz: begin
        if (abort)                            w_state_nxt = StIdle;
        else if (r_cnt == CNT_W'(N_AZ - 1))   w_state_nxt = StInt;
      end
      StInt: begin
        if (abort)                            w_state_nxt = StIdle;
        else if (r_cnt == CNT_W'(N_INT - 1))  w_state_nxt = StDeint;
      end
      StDeint: begin
        if (abort)            w_state_nxt = StIdle;
        else if (w_deint_end) w_state_nxt = StDone;
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_ch_zr     <= 1'b1;
      r_ch_vm     <= 1'b0;
      r_ch_ref    <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_overrange <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      // Counter restarts on every state change and idles at zero.
      if ((w_state_nxt != r_state) || (w_state_nxt == StIdle)) r_cnt <= '0;
      else                                                      r_cnt <= r_cnt + 1'b1;
      r_ch_zr  <= (w_state_nxt == StIdle) || (w_state_nxt == StAz) ||
                  (w_state_nxt == StDone);
      r_ch_vm  <= (w_state_nxt == StInt);
      r_ch_ref <= (w_state_nxt == StDeint);
      r_busy   <= (w_state_nxt == StAz) || (w_state_nxt == StInt) ||
                  (w_state_nxt == StDeint);
      r_valid  <= (w_state_nxt == StDone);
      if (w_deint_end) begin
        r_result    <= vint_z ? r_cnt : CNT_W'(N_MAX);
        r_overrange <= !vint_z;
      end
    end
  end

  assign ch_vm     = r_ch_vm;
  assign ch_ref    = r_ch_ref;
  assign ch_zr     = r_ch_zr;
  assign busy      = r_busy;
  assign valid     = r_valid;
  assign result    = r_result;
  assign overrange = r_overrange;

endmodule

// File: tb/tb_dual_slope_sequencer.sv
module tb_dual_slope_sequencer;

  localparam int unsigned N_AZ  = 4;
  localparam int unsigned N_INT = 10;
  localparam int unsigned N_MAX = 20;
  localparam int unsigned CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             vint_z = 1'b0;
  logic             ch_vm, ch_ref, ch_zr, busy, valid, overrange;
  logic [CNT_W-1:0] result;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;
  logic prev_valid = 1'b0;

  dual_slope_sequencer #(
    .N_AZ (N_AZ),
    .N_INT(N_INT),
    .N_MAX(N_MAX),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .vint_z   (vint_z),
    .ch_vm    (ch_vm),
    .ch_ref   (ch_ref),
    .ch_zr    (ch_zr),
    .busy     (busy),
    .valid    (valid),
    .result   (result),
    .overrange(overrange)
  );

  always #5 clk = ~clk;

  // Continuous invariants: switches one-hot, valid never two cycles in a row.
  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if ($countones({ch_zr, ch_vm, ch_ref}) != 1) begin
        miscompares++;
        $display("FAIL onehot: ch_zr/vm/ref=%b%b%b required exactly one high", ch_zr, ch_vm, ch_ref);
      end
      vectors++;
      if (prev_valid === 1'b1 && valid === 1'b1) begin
        miscompares++;
        $display("FAIL valid_width: valid high 2 cycles, required 1");
      end
      prev_valid <= valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one conversion from IDLE, recording phase lengths and the valid pulse.
  // hit < 0 keeps vint_z low in DEINT; vz_early drives vint_z in AZ/INT.
  task automatic run_conv(input int hit, input bit vz_early, input bit poke_start,
                          output int n_az, output int n_int, output int n_ref,
                          output int n_valid, output logic [CNT_W-1:0] res,
                          output logic ovr, output bit timeout);
    n_az = 0; n_int = 0; n_ref = 0; n_valid = 0; res = 'x; ovr = 1'bx; timeout = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!busy && !valid) begin
        timeout = 1'b0;
        break;
      end
      if (valid) begin
        n_valid++;
        res = result;
        ovr = overrange;
      end
      if (busy && ch_zr) n_az++;
      if (ch_vm) n_int++;
      if (ch_ref) n_ref++;
      vint_z = ch_ref ? ((n_ref - 1) == hit) : (vz_early && busy);
      start  = poke_start && busy && (c % 3 == 0);
      step();
    end
    vint_z = 1'b0;
    start  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    step();
    step();
    mon_en = 1'b1;
    vectors++;
    if ({ch_zr, ch_vm, ch_ref, busy, valid, overrange} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_outputs: zr/vm/ref/busy/valid/ovr=%b required 100000",
               {ch_zr, ch_vm, ch_ref, busy, valid, overrange});
    end
    vectors++;
    if (result !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_result: got %0d required 0", result);
    end
    reset = 1'b0;
    start = 1'b0;
    step();
    vectors++;
    if (busy !== 1'b0 || ch_zr !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b ch_zr=%b required 0,1", busy, ch_zr);
    end
  endtask

  task automatic test_normal();
    int na, ni, nr, nv;
    logic [CNT_W-1:0] r;
    logic o;
    bit to;
    run_conv(6, 1'b0, 1'b0, na, ni, nr, nv, r, o, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL normal_timeout: no return to IDLE in 200 cycles"); end
    vectors++;
    if (na != 4) begin miscompares++; $display("FAIL normal_az_len: got %0d required 4", na); end
    vectors++;
    if (ni != 10) begin miscompares++; $display("FAIL normal_int_len: got %0d required 10", ni); end
    vectors++;
    if (nr != 7) begin miscompares++; $display("FAIL normal_ref_len: got %0d required 7", nr); end
    vectors++;
    if (nv != 1) begin miscompares++; $display("FAIL normal_valid_cnt: got %0d required 1", nv); end
    vectors++;
    if (r !== 5'd6 || o !== 1'b0) begin
      miscompares++;
      $display("FAIL normal_result: got %0d/%b required 6/0", r, o);
    end
    vectors++;
    if (ch_zr !== 1'b1) begin miscompares++; $display("FAIL normal_idle_zr: got %b required 1", ch_zr); end
  endtask

  task automatic test_timeout();
    int na, ni, nr, nv;
    logic [CNT_W-1:0] r;
    logic o;
    bit to;
    run_conv(-1, 1'b0, 1'b0, na, ni, nr, nv, r, o, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL ovr_timeout: no return to IDLE in 200 cycles"); end
    vectors++;
    if (nr != 20) begin miscompares++; $display("FAIL ovr_ref_len: got %0d required 20", nr); end
    vectors++;
    if (nv != 1) begin miscompares++; $display("FAIL ovr_valid_cnt: got %0d required 1", nv); end
    vectors++;
    if (r !== 5'd20 || o !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_result: got %0d/%b required 20/1", r, o);
    end
  endtask

  task automatic test_abort();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (valid !== 1'b0) begin miscompares++; $display("FAIL abort_pre_valid: got %b required 0", valid); end
      step();
    end
    // Now in the 5th INT cycle.
    vectors++;
    if (ch_vm !== 1'b1) begin miscompares++; $display("FAIL abort_in_int: ch_vm=%b required 1", ch_vm); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    vectors++;
    if (ch_zr !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_int_idle: zr/busy/valid=%b%b%b required 100", ch_zr, busy, valid);
    end
    vectors++;
    if (result !== 5'd20 || overrange !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_int_hold: got %0d/%b required 20/1", result, overrange);
    end
    step();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_stays_idle: busy=%b required 0", busy); end
    // Abort together with vint_z in DEINT.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 14; i++) step();
    vectors++;
    if (ch_ref !== 1'b1) begin miscompares++; $display("FAIL abort_in_deint: ch_ref=%b required 1", ch_ref); end
    abort  = 1'b1;
    vint_z = 1'b1;
    step();
    abort  = 1'b0;
    vint_z = 1'b0;
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0 || ch_zr !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_deint_idle: valid/busy/zr=%b%b%b required 001", valid, busy, ch_zr);
    end
    vectors++;
    if (result !== 5'd20 || overrange !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_deint_hold: got %0d/%b required 20/1", result, overrange);
    end
    step();
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL abort_deint_novalid: got %b required 0", valid); end
  endtask

  task automatic test_early_vz();
    int na, ni, nr, nv;
    logic [CNT_W-1:0] r;
    logic o;
    bit to;
    run_conv(0, 1'b1, 1'b1, na, ni, nr, nv, r, o, to);
    vectors++;
    if (to) begin miscompares++; $display("FAIL early_timeout: no return to IDLE in 200 cycles"); end
    vectors++;
    if (na != 4 || ni != 10) begin
      miscompares++;
      $display("FAIL early_phase_len: az=%0d int=%0d required 4,10", na, ni);
    end
    vectors++;
    if (nr != 1) begin miscompares++; $display("FAIL early_ref_len: got %0d required 1", nr); end
    vectors++;
    if (nv != 1 || r !== 5'd0 || o !== 1'b0) begin
      miscompares++;
      $display("FAIL early_result: valid=%0d res=%0d ovr=%b required 1,0,0", nv, r, o);
    end
  endtask

  task automatic test_back_to_back();
    int first_valid = -1;
    int rise = -1;
    int dix = 0;
    bit seen_ref = 1'b0;
    start = 1'b1;
    step();
    for (int c = 0; c < 60; c++) begin
      if (valid && first_valid < 0) first_valid = c;
      if (first_valid >= 0 && c > first_valid && busy) begin
        rise = c;
        break;
      end
      if (ch_ref) begin
        vint_z = (dix == 2);
        dix++;
      end else begin
        vint_z = 1'b0;
      end
      step();
    end
    vint_z = 1'b0;
    vectors++;
    if (first_valid != 17) begin
      miscompares++;
      $display("FAIL b2b_done_cycle: got %0d required 17", first_valid);
    end
    vectors++;
    if (rise != 19) begin miscompares++; $display("FAIL b2b_restart_cycle: got %0d required 19", rise); end
    vectors++;
    if (result !== 5'd2 || overrange !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_result: got %0d/%b required 2/0", result, overrange);
    end
    for (int i = 0; i < 30; i++) begin
      if (ch_ref) begin
        seen_ref = 1'b1;
        break;
      end
      step();
    end
    vectors++;
    if (!seen_ref) begin miscompares++; $display("FAIL b2b_deint: DEINT not reached within 30 cycles"); end
    step();
    reset = 1'b1;
    start = 1'b0;
    step();
    vectors++;
    if ({ch_zr, ch_vm, ch_ref, busy, valid, overrange} !== 6'b100000 || result !== 5'd0) begin
      miscompares++;
      $display("FAIL midreset: zr/vm/ref/busy/valid/ovr=%b res=%0d required 100000 res=0",
               {ch_zr, ch_vm, ch_ref, busy, valid, overrange}, result);
    end
    reset = 1'b0;
    step();
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_idle: valid=%b busy=%b required 0,0", valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_abort();
    test_early_vz();
    test_back_to_back();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
